// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the fetch port (stage one) and the
//   data port (stage three). Grants one requester per access, drives the memory strobes for one
//   cycle and returns read data or a write acknowledge to the winner. Data wins ties.
//
//   Optional feature: define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after MAX_WAIT
//   consecutive data grants taken while a fetch was waiting.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   halt_sys_i           blocks new grants; in-flight access still completes
//   if_*                 fetch request/grant/response, if_stall_o = if_req_i & ~if_gnt_o
//   d_*                  data request/grant/response (d_rdata_o = 0 on write completion)
//   mem_*                registered memory strobes, non-zero only in the ISSUE cycle
//   busy_o               FSM not idle
module mem_port_arbiter #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned LATENCY  = 1,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              halt_sys_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_stall_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   localparam int unsigned LatW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   if (LATENCY < 1 || MAX_WAIT < 1) begin : gen_bad_param
      $error("mem_port_arbiter: LATENCY and MAX_WAIT must be >= 1");
   end

   state_e            state_q;
   logic              owner_d_q;   // 1: data port owns the access in flight
   logic              we_q;
   logic [LatW-1:0]   lat_cnt_q;
   logic              mem_en_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              if_rvalid_q, d_rvalid_q;
   logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

   logic arb_en;
   logic force_if;
   logic if_gnt, d_gnt;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int unsigned StarveW = $clog2(MAX_WAIT + 1);
   logic [StarveW-1:0] starve_q;

   assign force_if = (starve_q == StarveW'(MAX_WAIT));

   // Counts data wins over a waiting fetch; saturates at MAX_WAIT.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_q <= '0;
      end else if (if_gnt) begin
         starve_q <= '0;
      end else if (d_gnt && if_req_i && !force_if) begin
         starve_q <= starve_q + StarveW'(1);
      end
   end
`else
   assign force_if = 1'b0;
`endif

   // RESP arbitrates like IDLE so back-to-back accesses run every LATENCY+2 cycles.
   assign arb_en = ((state_q == StIdle) || (state_q == StResp)) && !halt_sys_i;
   assign d_gnt  = arb_en && d_req_i && !(force_if && if_req_i);
   assign if_gnt = arb_en && if_req_i && (!d_req_i || force_if);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         owner_d_q   <= 1'b0;
         we_q        <= 1'b0;
         lat_cnt_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         // Strobes and pulses default low; only one cycle per access/response.
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         unique case (state_q)
            StIdle, StResp: begin
               if (if_gnt || d_gnt) begin
                  owner_d_q   <= d_gnt;
                  we_q        <= d_gnt && d_we_i;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= d_gnt && d_we_i;
                  mem_addr_q  <= d_gnt ? d_addr_i : if_addr_i;
                  mem_wdata_q <= d_gnt ? d_wdata_i : '0;
                  state_q     <= StIssue;
               end else begin
                  state_q <= StIdle;
               end
            end
            StIssue: begin
               lat_cnt_q <= LatW'(LATENCY - 1);
               state_q   <= StWait;
            end
            StWait: begin
               if (lat_cnt_q == '0) begin
                  if (owner_d_q) begin
                     d_rvalid_q <= 1'b1;
                     d_rdata_q  <= we_q ? '0 : mem_rdata_i;
                  end else begin
                     if_rvalid_q <= 1'b1;
                     if_rdata_q  <= mem_rdata_i;
                  end
                  state_q <= StResp;
               end else begin
                  lat_cnt_q <= lat_cnt_q - LatW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign if_gnt_o    = if_gnt;
   assign d_gnt_o     = d_gnt;
   assign if_stall_o  = if_req_i && !if_gnt;
   assign if_rvalid_o = if_rvalid_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rvalid_o  = d_rvalid_q;
   assign d_rdata_o   = d_rdata_q;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign busy_o      = (state_q != StIdle);

endmodule
